regfile_wb_arbiter: RTL

- Shares the single write port of the 32x32 register file among NUM_REQ writeback requesters (ALU, load unit, mul/div) using round-robin valid/ready arbitration.
- Drives the register file's reg_write/w_addr/w_data from a registered stage.
- Keeps a per-register pending-write scoreboard so issue logic can stall on in-flight destinations.

---
 rtl/regfile_wb_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Purpose: round-robin share of the register file write port plus a pending-write scoreboard.
// Latency: 1 cycle from accept to reg_write; busy bits update at the edge; rsN_busy is combinational.
// Backpressure: one requester is granted per cycle; the register file never stalls the write stage.
// Optional bypass outputs are compiled in with `define REGFILE_WB_BYPASS_EN.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      issue_valid,
  input  logic [ADDR_W-1:0]         issue_rd,
  input  logic [ADDR_W-1:0]         rs1_addr,
  input  logic [ADDR_W-1:0]         rs2_addr,
  output logic                      rs1_busy,
  output logic                      rs2_busy,
`ifdef REGFILE_WB_BYPASS_EN
  output logic                      byp1_hit,
  output logic                      byp2_hit,
  output logic [DATA_W-1:0]         byp1_data,
  output logic [DATA_W-1:0]         byp2_data,
`endif
  output logic                      reg_write,
  output logic [ADDR_W-1:0]         w_addr,
  output logic [DATA_W-1:0]         w_data
);

  localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NREG = 1 << ADDR_W;

  logic [RR_W-1:0]   rr;
  logic [RR_W-1:0]   gnt_idx;
  logic [RR_W-1:0]   rr_next;
  logic              found;
  logic              accept;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_nxt;

  // Grant the first valid requester at or after rr, wrapping; nothing is granted in reset.
  always_comb begin
    req_ready = '0;
    found     = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_valid[i] &&
            ((int'(rr) + k == i) || (int'(rr) + k == i + NUM_REQ))) begin
          req_ready[i] = 1'b1;
          found        = 1'b1;
          gnt_idx      = RR_W'(i);
        end
      end
    end
    if (!reset) begin
      req_ready = '0;
      found     = 1'b0;
    end
  end

  assign accept = found;

  // Pointer moves to the slot just after the winner so the winner goes last next round.
  always_comb begin
    if (gnt_idx == RR_W'(NUM_REQ - 1)) rr_next = '0;
    else                               rr_next = gnt_idx + RR_W'(1);
  end

  // Select the granted requester's address and data.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Registered write stage; x0 writes are consumed but never raise reg_write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_write <= 1'b0;
      w_addr    <= '0;
      w_data    <= '0;
      rr        <= '0;
    end else begin
      reg_write <= accept && (sel_addr != '0);
      if (accept) begin
        w_addr <= sel_addr;
        w_data <= sel_data;
        rr     <= rr_next;
      end
    end
  end

  // Next busy vector: commit clears first, then a new issue sets, so the newer producer wins.
  always_comb begin
    busy_nxt = busy;
    if (reg_write) busy_nxt[w_addr] = 1'b0;
    if (issue_valid && (issue_rd != '0)) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy <= '0;
    else        busy <= busy_nxt;
  end

`ifdef REGFILE_WB_BYPASS_EN
  // A source matching the committing write can take w_data directly, so it is not a stall.
  always_comb begin
    byp1_hit  = reg_write && (w_addr == rs1_addr) && (rs1_addr != '0);
    byp2_hit  = reg_write && (w_addr == rs2_addr) && (rs2_addr != '0);
    byp1_data = w_data;
    byp2_data = w_data;
    rs1_busy  = busy[rs1_addr] && !byp1_hit;
    rs2_busy  = busy[rs2_addr] && !byp2_hit;
  end
`else
  // Source busy straight from the scoreboard.
  always_comb begin
    rs1_busy = busy[rs1_addr];
    rs2_busy = busy[rs2_addr];
  end
`endif

endmodule
